// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the IF and MEM pipeline stages.
// Each access is a request/ready handshake guarded by a watchdog; MEM wins ties.
module mem_port_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  input  logic                if_flush,
  output logic                if_done,
  output logic [DATA_LEN-1:0] if_rdata,
  output logic                if_stall,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_LEN-1:0] mem_addr_in,
  input  logic [DATA_LEN-1:0] mem_wdata_in,
  output logic                mem_done,
  output logic [DATA_LEN-1:0] mem_rdata,
  output logic                mem_stall,
  output logic                port_req,
  output logic                port_we,
  output logic [ADDR_LEN-1:0] port_addr,
  output logic [DATA_LEN-1:0] port_wdata,
  input  logic [DATA_LEN-1:0] port_rdata,
  input  logic                port_ready,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_ACC   = 3'd1,
    S_MEM_ACC  = 3'd2,
    S_IF_DONE  = 3'd3,
    S_MEM_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                port_req_q, port_req_d;
  logic                port_we_q, port_we_d;
  logic [ADDR_LEN-1:0] port_addr_q, port_addr_d;
  logic [DATA_LEN-1:0] port_wdata_q, port_wdata_d;
  logic [DATA_LEN-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_LEN-1:0] mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic                timeout_err_q, timeout_err_d;

  logic                mem_any_s;
  logic                cnt_last_s;
  logic                in_acc_s;
  logic                if_drop_s;

  assign mem_any_s  = mem_r_en | mem_w_en;
  assign cnt_last_s = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign in_acc_s   = (state_q == S_IF_ACC) || (state_q == S_MEM_ACC);
  // A flush in any fetch cycle, including the completing one, discards the fetch.
  assign if_drop_s  = abort_q | if_flush;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      port_req_q    <= 1'b0;
      port_we_q     <= 1'b0;
      port_addr_q   <= '0;
      port_wdata_q  <= '0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      if_done_q     <= 1'b0;
      mem_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
      port_req_q    <= port_req_d;
      port_we_q     <= port_we_d;
      port_addr_q   <= port_addr_d;
      port_wdata_q  <= port_wdata_d;
      if_rdata_q    <= if_rdata_d;
      mem_rdata_q   <= mem_rdata_d;
      if_done_q     <= if_done_d;
      mem_done_q    <= mem_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_any_s) begin
          state_d = S_MEM_ACC;
        end else if (if_req && !if_flush) begin
          state_d = S_IF_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IF_ACC: begin
        if (port_ready) begin
          state_d = if_drop_s ? S_IDLE : S_IF_DONE;
        end else if (cnt_last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IF_ACC;
        end
      end
      S_MEM_ACC: begin
        if (port_ready) begin
          state_d = S_MEM_DONE;
        end else if (cnt_last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MEM_ACC;
        end
      end
      S_IF_DONE:  state_d = S_IDLE;
      S_MEM_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath, derived from the current and next state.
  always_comb begin
    port_req_d    = (state_d == S_IF_ACC) || (state_d == S_MEM_ACC);
    if_done_d     = (state_d == S_IF_DONE);
    mem_done_d    = (state_d == S_MEM_DONE);
    port_we_d     = port_we_q;
    port_addr_d   = port_addr_q;
    port_wdata_d  = port_wdata_q;
    if_rdata_d    = if_rdata_q;
    mem_rdata_d   = mem_rdata_q;
    abort_d       = abort_q;
    cnt_d         = '0;
    timeout_err_d = timeout_err_q;

    // Access parameters are captured once on entry and then held.
    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
      if (state_d == S_MEM_ACC) begin
        port_we_d    = mem_w_en & ~mem_r_en;
        port_addr_d  = mem_addr_in;
        port_wdata_d = mem_wdata_in;
      end else if (state_d == S_IF_ACC) begin
        port_we_d   = 1'b0;
        port_addr_d = if_addr;
      end else begin
        port_we_d = port_we_q;
      end
    end else if (in_acc_s) begin
      if (state_q == S_IF_ACC) begin
        abort_d = if_drop_s;
      end else begin
        abort_d = abort_q;
      end
      if (port_ready) begin
        if ((state_q == S_IF_ACC) && !if_drop_s) begin
          if_rdata_d = port_rdata;
        end else if ((state_q == S_MEM_ACC) && !port_we_q) begin
          mem_rdata_d = port_rdata;
        end else begin
          if_rdata_d = if_rdata_q;
        end
      end else if (cnt_last_s) begin
        timeout_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      abort_d = abort_q;
    end
  end

  assign if_done     = if_done_q & ~if_flush;
  assign mem_done    = mem_done_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_stall    = if_req & ~if_done;
  assign mem_stall   = mem_any_s & ~mem_done;
  assign port_req    = port_req_q;
  assign port_we     = port_we_q;
  assign port_addr   = port_addr_q;
  assign port_wdata  = port_wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requesting stages and a memory with
// random latency, checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_r_en, mem_w_en, mem_done, mem_stall;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_wdata_in, mem_rdata;
  logic          port_req, port_we, port_ready, timeout_err;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata, port_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the port, how long the access has waited,
  // which stage is receiving its completion this cycle.
  int            m_owner;   // 0 none, 1 IF, 2 MEM
  int            m_done;    // 0 none, 1 IF, 2 MEM
  int            m_cnt;
  int            m_lat;
  bit            m_abort;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_mem_rdata;
  bit            m_terr;
  bit            prev_if_done, prev_mem_done, prev_flush;

  mem_port_arbiter #(.ADDR_LEN(AW), .DATA_LEN(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr_in(mem_addr_in),
    .mem_wdata_in(mem_wdata_in), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .port_req(port_req), .port_we(port_we),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
    .port_ready(port_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_done = 0; m_cnt = 0; m_lat = 0; m_abort = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_if_rdata = '0; m_mem_rdata = '0; m_terr = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    prev_if_done  = (m_done == 1) && !if_flush;
    prev_mem_done = (m_done == 2);
    prev_flush    = if_flush;
    if (!rst) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (m_owner == 1 && if_flush) m_abort = 1'b1;
      if (port_ready) begin
        if (m_owner == 1) begin
          if (!m_abort) begin
            m_if_rdata = port_rdata;
            m_done = 1;
          end
        end else begin
          if (!m_we) m_mem_rdata = port_rdata;
          m_done = 2;
        end
        m_owner = 0;
      end else if (m_cnt == TO - 1) begin
        m_terr  = 1'b1;
        m_owner = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_done != 0) begin
      m_done = 0;
    end else begin
      m_abort = 1'b0;
      m_cnt   = 0;
      m_lat   = ($urandom % 8 == 0) ? TO + 1 : int'($urandom % 4);
      if (mem_r_en || mem_w_en) begin
        m_owner = 2;
        m_we    = mem_w_en && !mem_r_en;
        m_addr  = mem_addr_in;
        m_wdata = mem_wdata_in;
      end else if (if_req && !if_flush) begin
        m_owner = 1;
        m_we    = 1'b0;
        m_addr  = if_addr;
      end
    end
  endtask

  task automatic new_mem_request(input bit maybe_idle);
    int sel;
    sel = int'($urandom % 5);
    if (maybe_idle && sel == 4) begin
      mem_r_en = 1'b0; mem_w_en = 1'b0;
    end else begin
      mem_r_en     = (sel != 2);
      mem_w_en     = (sel >= 2);
      mem_addr_in  = $urandom & 32'hFFFF_FFFC;
      mem_wdata_in = $urandom;
    end
  endtask

  // Stages behave like pipeline registers: hold until done, advance after it.
  task automatic drive_inputs(input int cyc);
    rst = (cyc < 2) ? 1'b0 : ($urandom % 200 != 0);
    if (prev_if_done || prev_flush) begin
      if_req  = ($urandom % 4 != 0);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (!if_req && ($urandom % 3 == 0)) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if_flush = prev_flush ? 1'b0 : ($urandom % 12 == 0);
    if (prev_mem_done) begin
      new_mem_request(1'b1);
    end else if (!(mem_r_en || mem_w_en) && ($urandom % 4 == 0)) begin
      new_mem_request(1'b0);
    end
    if (m_owner != 0) port_ready = (m_cnt == m_lat);
    else              port_ready = ($urandom % 3 == 0);
    port_rdata = $urandom;
  endtask

  task automatic check_outputs();
    bit exp_if_done, exp_mem_done;
    exp_if_done  = (m_done == 1) && !if_flush;
    exp_mem_done = (m_done == 2);
    check_eq("port_req",    32'(port_req),    32'(m_owner != 0));
    check_eq("port_we",     32'(port_we),     32'(m_we));
    check_eq("port_addr",   port_addr,        m_addr);
    check_eq("port_wdata",  port_wdata,       m_wdata);
    check_eq("if_rdata",    if_rdata,         m_if_rdata);
    check_eq("mem_rdata",   mem_rdata,        m_mem_rdata);
    check_eq("if_done",     32'(if_done),     32'(exp_if_done));
    check_eq("mem_done",    32'(mem_done),    32'(exp_mem_done));
    check_eq("if_stall",    32'(if_stall),    32'(if_req && !exp_if_done));
    check_eq("mem_stall",   32'(mem_stall),   32'((mem_r_en || mem_w_en) && !exp_mem_done));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr_in = '0; mem_wdata_in = '0;
    port_ready = 1'b0; port_rdata = '0;
    prev_if_done = 1'b0; prev_mem_done = 1'b0; prev_flush = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      drive_inputs(cyc);
      @(negedge clk);
      check_outputs();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the instruction-fetch (IF) stage and the MEM stage of the 5-stage pipeline. Sequences each access through a request/ready handshake with the memory. Returns fetched or loaded data to the requesting stage. Generates per-stage stall signals that freeze the pipeline registers until the stage's access completes.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data word width
- TIMEOUT, 15, max cycles in an access state without mem_ready before a forced abort (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- if_req  in  1  IF stage requests an instruction read; held until if_done
- if_addr  in  ADDR_LEN  fetch address (PC)
- if_flush  in  1  branch taken; the in-flight fetch is discarded
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_LEN  fetched instruction, registered
- if_stall  out  1  if_req & ~if_done
- mem_r_en, mem_w_en  in  1 each  MEM stage read/write request (from the EXE/MEM register); held until mem_done; both high = read
- mem_addr_in  in  ADDR_LEN  data address (ALU result)
- mem_wdata_in  in  DATA_LEN  store data
- mem_done  out  1  one-cycle pulse; mem_rdata valid for loads
- mem_rdata  out  DATA_LEN  loaded word, registered
- mem_stall  out  1  (mem_r_en|mem_w_en) & ~mem_done
- port_req  out  1  memory request, registered
- port_we  out  1  1 = write
- port_addr  out  ADDR_LEN  latched address
- port_wdata  out  DATA_LEN  latched write data
- port_rdata  in  DATA_LEN  valid when port_ready=1
- port_ready  in  1  access complete; sampled only while port_req=1
- timeout_err  out  1  sticky; set on a watchdog abort, cleared only by reset

## Operation
- States: IDLE, IF_ACC, MEM_ACC, IF_DONE, MEM_DONE.
- IDLE:
  - MEM stage request → MEM_ACC; MEM has priority over IF because it carries the older instruction.
  - Else if_req & ~if_flush → IF_ACC.
  - On entry to an ACC state, latch port_addr/port_wdata/port_we and clear the watchdog counter.
- X_ACC:
  - port_req=1.
  - port_ready=1 → capture port_rdata into the stage's rdata register (loads and fetches only) and go to X_DONE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and still no ready: go to IDLE, set timeout_err, no done pulse.
- IF_ACC abort: if_flush=1 in any IF_ACC cycle sets an internal abort flag. At completion the flag sends the FSM to IDLE instead of IF_DONE, so if_rdata is not updated. The flag clears in IDLE.
- X_DONE: port_req=0, the stage's done=1 for exactly this cycle, then IDLE. if_flush=1 during IF_DONE masks if_done to 0.
- Latched port_addr/wdata/we are stable for the entire ACC state. Input changes mid-access are ignored.
- Stores: mem_rdata is unchanged.
- Reset: state IDLE, port_req=0, port_we=0, port_addr=0, port_wdata=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, timeout_err=0, abort flag=0, counter=0.
- Reset asserted mid-access: port_req drops on the next edge. No done is issued.

## Timing
- A request seen in IDLE at cycle n gives port_req=1 at n+1.
- port_ready at cycle k (k≥n+1) gives done=1 at k+1 and IDLE at k+2. Minimum request-to-done latency is 2 cycles; one access per 3 cycles at best.
- A stage's pipeline register advances on the edge that ends its done cycle. In the following IDLE cycle, the request reflects the next instruction.
- IF and MEM requests in the same IDLE cycle: MEM is served first. IF is served from the next IDLE cycle, with if_stall held throughout.
- port_ready outside ACC states is ignored.
- if_stall/mem_stall are combinational from registered done and the inputs.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, port_ready at the first port_req cycle with port_rdata=0xA5A5_0001 → port_req cycles n+1 only, if_done and if_rdata=0xA5A5_0001 at n+2, IDLE at n+3.
- Simultaneous requests: if_req=1 and mem_r_en=1 (addr 0x100) in the same cycle; memory answers after 2 cycles → MEM access completes first (mem_done), then port_addr=if_addr and if_done. if_stall stays high until its own done.
- Store: mem_w_en=1, addr 0x40, wdata 0xDEAD_BEEF, ready after 3 cycles → port_we=1 with stable addr/wdata over 3 cycles, mem_done pulse, mem_rdata unchanged.
- Flush: if_flush pulsed in the 2nd IF_ACC cycle, ready on the 3rd → no if_done, if_rdata keeps its old value, IDLE the cycle after ready.
- Timeout: TIMEOUT=4, port_ready held 0 → port_req high 4 cycles, then IDLE, timeout_err=1 permanently, no done. The next request is served normally.
- Reset mid-access: rst=0 during MEM_ACC → all outputs at their reset values after the edge, and no mem_done when rst returns high.
